// File: rtl/sipo_block_buffer_if.sv
// Stream bundle for the block buffer: word input side and block output side.
// slave is the buffer's view; master is the upstream producer plus absorb-stage consumer.
interface sipo_block_buffer_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 17
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [DEPTH*WIDTH-1:0] data_out;
    logic [CW-1:0]          out_count;
    logic                   out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, data_out, out_count, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, data_out, out_count, out_last
    );
endinterface

// File: rtl/sipo_block_buffer.sv
// Serial-in/parallel-out block assembler: packs WIDTH-bit words into a DEPTH-word block
// held on a valid/ready output, with early close on in_last and zero fill of unused slots.
module sipo_block_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] word_d, word_q;

    // A write in the release cycle lands the first word of the next block, so it beats the clear.
    always_comb begin
        word_d = word_q;
        if (wr_en)    word_d = wr_data;
        else if (clr) word_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end

    assign word = word_q;
endmodule

module sipo_block_buffer #(
    parameter int WIDTH          = 64,
    parameter int DEPTH          = 17,
    parameter bit FIRST_WORD_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sipo_block_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {FILL, HOLD} state_e;

    state_e                      state_d, state_q;
    logic   [CW-1:0]             wr_cnt_d, wr_cnt_q;
    logic   [CW-1:0]             count_d, count_q;
    logic                        last_d, last_q;
    logic                        acc, rel, closes;
    logic   [CW-1:0]             nxt_cnt;
    logic   [DEPTH-1:0][WIDTH-1:0] slot_word;

    assign bus.out_valid = (state_q == HOLD);
    assign bus.in_ready  = (state_q == FILL) || bus.out_ready;
    assign acc           = bus.in_valid && bus.in_ready;
    assign rel           = bus.out_valid && bus.out_ready;

    // wr_cnt_q is already 0 in HOLD, so a word accepted alongside a release goes to slot 0.
    assign nxt_cnt = wr_cnt_q + CW'(1);
    assign closes  = acc && ((nxt_cnt == CW'(DEPTH)) || bus.in_last);

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        count_d  = count_q;
        last_d   = last_q;
        if (rel) begin
            state_d = FILL;
            count_d = '0;
            last_d  = 1'b0;
        end
        if (acc) begin
            if (closes) begin
                state_d  = HOLD;
                wr_cnt_d = '0;
                count_d  = nxt_cnt;
                last_d   = bus.in_last;
            end else begin
                wr_cnt_d = nxt_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        sipo_block_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (acc && (wr_cnt_q == CW'(i))),
            .clr     (rel),
            .wr_data (bus.in_data),
            .word    (slot_word[i])
        );
        if (FIRST_WORD_MSB) begin : g_msb
            assign bus.data_out[(DEPTH-i)*WIDTH-1 -: WIDTH] = slot_word[i];
        end else begin : g_lsb
            assign bus.data_out[(i+1)*WIDTH-1 -: WIDTH] = slot_word[i];
        end
    end

    assign bus.out_count = count_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_sipo_block_buffer.sv
// Scoreboard bench: three buffers (DEPTH=4 MSB-first, DEPTH=4 LSB-first, DEPTH=1) against a queue model.
module tb_sipo_block_buffer;
    logic clk = 1'b0;
    logic rst;
    int   chk = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sipo_block_buffer_if #(.WIDTH(8), .DEPTH(4)) bm ();
    sipo_block_buffer_if #(.WIDTH(8), .DEPTH(4)) bl ();
    sipo_block_buffer_if #(.WIDTH(8), .DEPTH(1)) b1 ();

    sipo_block_buffer #(.WIDTH(8), .DEPTH(4), .FIRST_WORD_MSB(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
    sipo_block_buffer #(.WIDTH(8), .DEPTH(4), .FIRST_WORD_MSB(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
    sipo_block_buffer #(.WIDTH(8), .DEPTH(1), .FIRST_WORD_MSB(1'b1)) u_d1  (.clk(clk), .rst(rst), .bus(b1));

    assign bl.in_valid  = bm.in_valid;
    assign bl.in_data   = bm.in_data;
    assign bl.in_last   = bm.in_last;
    assign bl.out_ready = bm.out_ready;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a block is the list of accepted words, closed by a 4th word or by last.
    typedef struct { logic [31:0] dm; logic [31:0] dl; int cnt; bit last; } blk_t;
    typedef struct { logic [7:0] d; bit last; } b1_t;
    blk_t       q4[$];
    logic [7:0] cur[$];
    b1_t        q1[$];
    int         close4 = -10, close1 = -10;

    function automatic void model4(logic [7:0] d, bit l);
        blk_t b;
        cur.push_back(d);
        if (cur.size() == 4 || l) begin
            b.dm = 0; b.dl = 0;
            foreach (cur[k]) begin
                b.dm = b.dm | (32'(cur[k]) << (8 * (3 - k)));
                b.dl = b.dl | (32'(cur[k]) << (8 * k));
            end
            b.cnt = cur.size(); b.last = l;
            q4.push_back(b);
            cur.delete();
            close4 = cyc;
        end
    endfunction

    task automatic step4(bit v, logic [7:0] d, bit l, bit r);
        @(posedge clk); #1;
        bm.in_valid = v; bm.in_data = d; bm.in_last = l; bm.out_ready = r;
        #1;
        if (v && bm.in_ready) model4(d, l);
    endtask

    task automatic step1(bit v, logic [7:0] d, bit l, bit r);
        b1_t e;
        @(posedge clk); #1;
        b1.in_valid = v; b1.in_data = d; b1.in_last = l; b1.out_ready = r;
        #1;
        if (v && b1.in_ready) begin
            e.d = d; e.last = l;
            q1.push_back(e);
            close1 = cyc;
        end
    endtask

    task automatic reset_state_checks(string tag);
        check({tag, "_ovalid"}, bm.out_valid, 0);
        check({tag, "_data"},   bm.data_out, 0);
        check({tag, "_count"},  bm.out_count, 0);
        check({tag, "_olast"},  bm.out_last, 0);
        check({tag, "_iready"}, bm.in_ready, 1);
        check({tag, "_d1_ovalid"}, b1.out_valid, 0);
    endtask

    task automatic mid_reset(string tag);
        @(posedge clk); #3;
        bm.in_valid = 0;
        rst = 1;
        #1;
        reset_state_checks(tag);
        cur.delete(); q4.delete(); close4 = -10;
        repeat (2) @(posedge clk);
        #3 rst = 0;
    endtask

    // Monitor for the DEPTH=4 pair.
    logic        hold4 = 0;
    logic [31:0] hd4;
    logic [2:0]  hc4;
    logic        hl4;
    always @(negedge clk) begin
        blk_t e;
        if (rst) hold4 = 0;
        else begin
            check("m4_in_ready", bm.in_ready, !bm.out_valid || bm.out_ready);
            if (close4 == cyc - 1) check("m4_latency", bm.out_valid, 1);
            if (!bm.out_valid) begin
                check("m4_idle_count", bm.out_count, 0);
                check("m4_idle_last", bm.out_last, 0);
            end
            if (hold4) begin
                check("m4_hold_valid", bm.out_valid, 1);
                check("m4_hold_data", bm.data_out, hd4);
                check("m4_hold_count", bm.out_count, hc4);
                check("m4_hold_last", bm.out_last, hl4);
            end
            if (bm.out_valid && bm.out_ready) begin
                if (q4.size() == 0) check("m4_unexpected_block", 1, 0);
                else begin
                    e = q4.pop_front();
                    check("m4_data_msb", bm.data_out, e.dm);
                    check("m4_data_lsb", bl.data_out, e.dl);
                    check("m4_count", bm.out_count, e.cnt);
                    check("m4_count_lsb", bl.out_count, e.cnt);
                    check("m4_last", bm.out_last, e.last);
                    check("m4_lsb_valid", bl.out_valid, 1);
                end
            end
            hold4 = bm.out_valid && !bm.out_ready;
            hd4 = bm.data_out; hc4 = bm.out_count; hl4 = bm.out_last;
        end
    end

    // Monitor for the DEPTH=1 buffer.
    always @(negedge clk) begin
        b1_t e;
        if (!rst) begin
            if (close1 == cyc - 1) check("m1_latency", b1.out_valid, 1);
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) check("m1_unexpected_block", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("m1_data", b1.data_out, e.d);
                    check("m1_count", b1.out_count, 1);
                    check("m1_last", b1.out_last, e.last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        rst = 1;
        bm.in_valid = 0; bm.in_data = 0; bm.in_last = 0; bm.out_ready = 0;
        b1.in_valid = 0; b1.in_data = 0; b1.in_last = 0; b1.out_ready = 1;
        #12;
        reset_state_checks("reset");
        #11 rst = 0;

        // Full block, both word orders.
        step4(1, 8'h11, 0, 1); step4(1, 8'h22, 0, 1); step4(1, 8'h33, 0, 1); step4(1, 8'h44, 0, 1);
        step4(0, 0, 0, 0);
        check("t1_data_msb", bm.data_out, 32'h11223344);
        check("t2_data_lsb", bl.data_out, 32'h44332211);
        check("t1_count", bm.out_count, 4);
        check("t1_last", bm.out_last, 0);
        step4(0, 0, 0, 1);

        // Early close, zero fill, next block starts clean.
        step4(1, 8'hAA, 0, 1); step4(1, 8'hBB, 1, 1);
        step4(0, 0, 0, 0);
        check("t3_data", bm.data_out, 32'hAABB0000);
        check("t3_count", bm.out_count, 2);
        check("t3_last", bm.out_last, 1);
        step4(0, 0, 0, 1);
        step4(1, 8'hCC, 1, 1);
        step4(0, 0, 0, 0);
        check("t3_next_data", bm.data_out, 32'hCC000000);
        step4(0, 0, 0, 1);

        // Backpressure in HOLD, then simultaneous release and accept.
        step4(1, 8'h01, 0, 1); step4(1, 8'h02, 0, 1); step4(1, 8'h03, 0, 1); step4(1, 8'h04, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step4(1, 8'h55, 0, 0);
            check("t4_in_ready", bm.in_ready, 0);
            check("t4_data", bm.data_out, 32'h01020304);
        end
        step4(1, 8'h55, 0, 1);
        check("t4_in_ready_rel", bm.in_ready, 1);
        step4(0, 0, 0, 0);
        check("t4_next_data", bm.data_out, 32'h55000000);
        check("t4_next_valid", bm.out_valid, 0);
        step4(1, 8'h66, 0, 1); step4(1, 8'h77, 0, 1); step4(1, 8'h88, 0, 1);
        step4(0, 0, 0, 0);
        check("t4_block", bm.data_out, 32'h55667788);
        step4(0, 0, 0, 1);

        // Reset mid-block, then mid-HOLD.
        step4(1, 8'h9A, 0, 1); step4(1, 8'h9B, 0, 1);
        mid_reset("t6_fill");
        step4(1, 8'hA1, 0, 1); step4(1, 8'hA2, 0, 1); step4(1, 8'hA3, 0, 1); step4(1, 8'hA4, 0, 1);
        step4(0, 0, 0, 0);
        check("t6_clean_data", bm.data_out, 32'hA1A2A3A4);
        check("t6_clean_count", bm.out_count, 4);
        mid_reset("t6_hold");
        step4(1, 8'h5E, 0, 1); step4(1, 8'h5F, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step4($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        step4(1, 8'hEE, 1, 1);
        repeat (3) step4(0, 0, 0, 1);
        check("drain4_queue", q4.size(), 0);
        check("drain4_partial", cur.size(), 0);

        // DEPTH=1: continuous stream gives one block per cycle.
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            step1(1, d, $urandom_range(0, 1) == 1, 1);
            if (i > 0) begin
                check("t5_valid", b1.out_valid, 1);
                check("t5_track", b1.data_out, prev);
            end
            prev = d;
        end
        for (int i = 0; i < 200; i++)
            step1($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        repeat (3) step1(0, 0, 0, 1);
        check("drain1_queue", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule
